// File: rtl/ram_stream_fifo.sv
// ram_stream_fifo: stream FIFO built on an external two-port RAM with a 4-entry output buffer.
// Ports:
//   clock, reset (async, active-high), clear (sync flush)
//   s_valid/s_ready/s_data   upstream write stream
//   m_valid/m_ready/m_data   downstream read stream
//   count                    words held: RAM + read in flight + output buffer
//   ram_cen/ram_wen/ram_ren/ram_bwen/ram_waddr/ram_raddr/ram_wdata/ram_rdata  RAM port
module ram_stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [$clog2(DEPTH+4):0]      count,
  output logic                          ram_cen,
  output logic                          ram_wen,
  output logic                          ram_ren,
  output logic [DATA_WIDTH-1:0]         ram_bwen,
  output logic [$clog2(DEPTH)-1:0]      ram_waddr,
  output logic [$clog2(DEPTH)-1:0]      ram_raddr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic [DATA_WIDTH-1:0]         ram_rdata
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH = $clog2(DEPTH+4)+1;
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [CNT_WIDTH-1:0]  ram_cnt;
  logic                  issued_q, land_q;
  logic [2:0]            out_cnt;
  logic [1:0]            land_idx;
  logic [DATA_WIDTH-1:0] obuf [4];
  logic [DATA_WIDTH-1:0] obuf_d [4];
  logic                  write, issue, pop;
  // RAM data is valid the cycle after the read, so the landing cycle is the issued_q cycle
  assign land_q = issued_q;
  assign s_ready = !reset && !clear && ram_cnt != CNT_WIDTH'(DEPTH);
  assign write = s_valid && s_ready;
  // Credit counts words in the buffer plus the one in flight; the current pop earns no credit
  assign issue = !reset && !clear && ram_cnt != '0 && (out_cnt + 3'(issued_q)) < 3'd4;
  assign m_valid = out_cnt != 3'd0;
  assign pop = m_valid && m_ready && !clear;
  assign m_data = obuf[0];
  assign count = ram_cnt + CNT_WIDTH'(issued_q) + CNT_WIDTH'(out_cnt);
  assign ram_wen = write;
  assign ram_ren = issue;
  assign ram_cen = write || issue;
  assign ram_bwen = '1;
  assign ram_waddr = wptr;
  assign ram_raddr = rptr;
  assign ram_wdata = s_data;
  // A landing word goes behind the last valid entry after this cycle's shift
  assign land_idx = 2'(out_cnt - 3'(pop));
  always_comb begin
    obuf_d = obuf;
    if (pop)
      for (int i = 0; i < 3; i++) obuf_d[i] = obuf[i+1];
    if (land_q) obuf_d[land_idx] = ram_rdata;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      ram_cnt <= '0;
      issued_q <= 1'b0;
      out_cnt <= '0;
      obuf <= '{default: '0};
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      ram_cnt <= '0;
      issued_q <= 1'b0;
      out_cnt <= '0;
    end else begin
      wptr <= wptr + ADDR_WIDTH'(write);
      rptr <= rptr + ADDR_WIDTH'(issue);
      ram_cnt <= ram_cnt + CNT_WIDTH'(write) - CNT_WIDTH'(issue);
      issued_q <= issue;
      out_cnt <= out_cnt + 3'(land_q) - 3'(pop);
      obuf <= obuf_d;
    end
  end
endmodule
